pe_array_seq: RTL and testbench
===============================

# pe_array_seq

Job sequencer for the 5x5 FP16 systolic PE array. It accepts one matrix job as S operand slices over a valid/ready stream, where S is the filter size (1..5), and buffers them. It then clears the array and replays the slices with the diagonal skew the array needs (lane i delayed i cycles), drives `start` and `filter_size`, and waits for the array's `done`. It sits between the operand fetch logic and the PE array.

## Interface
- `DATA_WIDTH`, 16, FP16 element width.
- `N`, 5, array dimension / max filter size.
- `TIMEOUT`, 32, max DRAIN cycles waiting for `done`.

- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `in_valid` in 1: operand slice valid.
- `in_ready` out 1: sequencer accepts slice.
- `in_filter_size` in 3: job size S, sampled on first beat of a job.
- `in_a` in N*DATA_WIDTH: A slice; lane i = bits [i*DATA_WIDTH +: DATA_WIDTH].
- `in_b` in N*DATA_WIDTH: B slice, same lane packing.
- `pe_reset` out 1: active-low clear to array.
- `pe_start` out 1: array start.
- `pe_filter_size` out 3: S to array.
- `pe_a`, `pe_b` out N*DATA_WIDTH: skewed Current_A1..5 / Current_B1..5 (lane 0 = index 1).
- `pe_done` in 1: array done.
- `busy` out 1: high in every state except IDLE.
- `job_done` out 1: one-cycle pulse at job end.
- `job_err` out 1: valid with `job_done`; 1 = timeout.

## Operation
- States: IDLE, LOAD, CLEAR, STREAM, DRAIN.
- `in_ready` = 1 only in IDLE and LOAD. A beat transfers when `in_valid & in_ready`.
- IDLE: a beat latches S and stores the slice as buf[0].
  - S of 0 or >N is clamped to N.
  - Next state: LOAD if S>1, else CLEAR.
- LOAD: beat k stores buf[k]. The beat with k=S-1 moves to CLEAR. `in_valid` low stalls with no effect.
- CLEAR: one cycle.
  - `pe_reset`=0, `pe_start`=0, `pe_a`/`pe_b`=0.
  - Next state: STREAM with t=0.
- STREAM: runs t=0..2S-2.
  - Lane i<S drives buf[t-i] when 0≤t-i<S, else 0. Lanes ≥S drive 0.
  - `pe_start`=1. After t=2S-2, go to DRAIN.
- DRAIN: `pe_a`/`pe_b`=0, `pe_start`=1, timeout counter runs.
  - `pe_done`=1 → `job_done`=1, `job_err`=0 → IDLE.
  - Counter reaches TIMEOUT → `job_done`=1, `job_err`=1 → IDLE.
- `pe_done` is ignored outside DRAIN.
- After a job, `pe_start`, `pe_reset` and `pe_filter_size` hold their values through IDLE/LOAD so array results stay stable. They change only at the next job's CLEAR.
- Buffer contents are not cleared between jobs; only the first S entries are used.

## Timing
- All outputs are registered.
- Reset values:
  - `in_ready`=0, `pe_reset`=0, `pe_start`=0, `pe_filter_size`=5.
  - `pe_a`/`pe_b`=0, `busy`=0, `job_done`=0, `job_err`=0.
  - State = IDLE; `in_ready` rises on the first cycle after deassert.
- Last-beat edge to `pe_reset` low: 1 cycle. CLEAR lasts 1 cycle. STREAM lasts 2S-1 cycles.
- `pe_done` sampled high at edge e → `job_done` high for the cycle after e.
- Timeout: `job_done` with `job_err` asserts TIMEOUT+1 cycles after DRAIN entry when `pe_done` stays low.
- Reset asserted mid-job: immediate abort, all outputs to reset values, no `job_done`.
- `pe_done` and timeout in the same cycle: done wins, `job_err`=0.

## Configuration
- `PE_SEQ_PERF_CNT_EN` defined: adds output `perf_cycles`, 16 bits.
  - Counts cycles from the first-beat edge to `job_done`, saturating at 16'hFFFF.
  - Value is held until the next first beat; reset value 0.
- Not defined: the port and counter are absent; all other behaviour is identical.

## Test plan
- S=5, slices k: `in_a` all lanes = FP16 of k+1 (3C00, 4000, 4200, 4400, 4500), `in_b` all 16'hC000 → STREAM t=0 lane0=3C00, others 0. t=4 lanes0..4=4500, 4400, 4200, 4000, 3C00. t=8 lane4=4500, others 0. Model `pe_done` 3 cycles into DRAIN → `job_done`=1, `job_err`=0.
- S=1, one beat 3C00/C000 → one CLEAR cycle, one STREAM cycle with lane0 only, `pe_filter_size`=1.
- `in_filter_size`=7 → clamped, `pe_filter_size`=5, five beats required.
- `in_valid` gaps of 2 cycles between LOAD beats → identical STREAM output to the gap-free run.
- `pe_done` never asserted, TIMEOUT=32 → `job_done`=1, `job_err`=1 exactly 33 cycles after DRAIN entry.
- `reset` low during STREAM t=3 → outputs at reset values. The next S=2 job runs correctly; with `PE_SEQ_PERF_CNT_EN`, `perf_cycles`=2+1+3+k, where k is the number of DRAIN cycles.

Source files
------------

// File: rtl/pe_array_seq.sv
// pe_array_seq: job sequencer for the 5x5 FP16 systolic PE array.
// Buffers S operand slices from a valid/ready stream, clears the array,
// replays the slices with a per-lane diagonal skew (lane i delayed i cycles),
// then waits for the array's done or a timeout.
// Optional feature: define PE_SEQ_PERF_CNT_EN to add the 16-bit perf_cycles
// output (cycles from first beat to job_done, saturating).
module pe_array_seq #(
  parameter int DATA_WIDTH = 16,
  parameter int N          = 5,
  parameter int TIMEOUT    = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              in_filter_size,
  input  logic [N*DATA_WIDTH-1:0] in_a,
  input  logic [N*DATA_WIDTH-1:0] in_b,
  output logic                    pe_reset,
  output logic                    pe_start,
  output logic [2:0]              pe_filter_size,
  output logic [N*DATA_WIDTH-1:0] pe_a,
  output logic [N*DATA_WIDTH-1:0] pe_b,
  input  logic                    pe_done,
  output logic                    busy,
  output logic                    job_done,
`ifdef PE_SEQ_PERF_CNT_EN
  output logic                    job_err,
  output logic [15:0]             perf_cycles
`else
  output logic                    job_err
`endif
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int VW    = N * DATA_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_CLEAR  = 3'd2,
    ST_STREAM = 3'd3,
    ST_DRAIN  = 3'd4
  } state_t;

  state_t           state_r, state_n;
  logic [2:0]       s_r, s_n;        // latched (clamped) filter size
  logic [2:0]       cnt_r, cnt_n;    // beats stored so far
  logic [3:0]       t_r, t_n;        // STREAM step
  logic [TMO_W-1:0] tmo_r, tmo_n;    // DRAIN cycle counter
  logic [3:0]       t_last_s;
  logic [2:0]       clamp_s;
  logic             accept_s;
  logic             wr_en_s;
  logic [2:0]       wr_idx_s;
  logic             job_done_n, job_err_n;
  logic [3:0]       lane_d_s;
  logic [VW-1:0]    skew_a_s, skew_b_s;
  logic [VW-1:0]    buf_a_r [N];
  logic [VW-1:0]    buf_b_r [N];

  logic             in_ready_r, busy_r, job_done_r, job_err_r;
  logic             pe_reset_r, pe_start_r;
  logic [2:0]       pe_fs_r;
  logic [VW-1:0]    pe_a_r, pe_b_r;

  assign accept_s = in_valid & in_ready_r;
  assign t_last_s = {s_r, 1'b0} - 4'd2;
  assign clamp_s  = ((in_filter_size == 3'd0) || (in_filter_size > 3'(N))) ? 3'(N) : in_filter_size;

  // Next-state logic: beat capture, stream stepping, done/timeout detection.
  always_comb begin
    state_n    = state_r;
    s_n        = s_r;
    cnt_n      = cnt_r;
    t_n        = t_r;
    tmo_n      = tmo_r;
    wr_en_s    = 1'b0;
    wr_idx_s   = cnt_r;
    job_done_n = 1'b0;
    job_err_n  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          s_n      = clamp_s;
          wr_en_s  = 1'b1;
          wr_idx_s = 3'd0;
          cnt_n    = 3'd1;
          state_n  = (clamp_s > 3'd1) ? ST_LOAD : ST_CLEAR;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (accept_s) begin
          wr_en_s  = 1'b1;
          wr_idx_s = cnt_r;
          cnt_n    = cnt_r + 3'd1;
          if (cnt_r == (s_r - 3'd1)) begin
            state_n = ST_CLEAR;
          end else begin
            state_n = ST_LOAD;
          end
        end else begin
          state_n = ST_LOAD;
        end
      end
      ST_CLEAR: begin
        state_n = ST_STREAM;
        t_n     = 4'd0;
      end
      ST_STREAM: begin
        if (t_r == t_last_s) begin
          state_n = ST_DRAIN;
          tmo_n   = '0;
        end else begin
          t_n = t_r + 4'd1;
        end
      end
      ST_DRAIN: begin
        if (pe_done) begin
          job_done_n = 1'b1;
          job_err_n  = 1'b0;
          state_n    = ST_IDLE;
        end else if (tmo_r == TMO_W'(TIMEOUT)) begin
          job_done_n = 1'b1;
          job_err_n  = 1'b1;
          state_n    = ST_IDLE;
        end else begin
          tmo_n = tmo_r + {{(TMO_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Skewed lane data for the upcoming cycle: lane i shows slice t-i when valid.
  always_comb begin
    skew_a_s = '0;
    skew_b_s = '0;
    lane_d_s = 4'd0;
    for (int i = 0; i < N; i++) begin
      lane_d_s = t_n - 4'(i);
      if ((state_n == ST_STREAM) && (3'(i) < s_n) && (lane_d_s < {1'b0, s_n})) begin
        skew_a_s[i*DATA_WIDTH +: DATA_WIDTH] = buf_a_r[lane_d_s[2:0]][i*DATA_WIDTH +: DATA_WIDTH];
        skew_b_s[i*DATA_WIDTH +: DATA_WIDTH] = buf_b_r[lane_d_s[2:0]][i*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        skew_a_s[i*DATA_WIDTH +: DATA_WIDTH] = '0;
        skew_b_s[i*DATA_WIDTH +: DATA_WIDTH] = '0;
      end
    end
  end

  // State and job bookkeeping registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      s_r     <= 3'(N);
      cnt_r   <= 3'd0;
      t_r     <= 4'd0;
      tmo_r   <= '0;
    end else begin
      state_r <= state_n;
      s_r     <= s_n;
      cnt_r   <= cnt_n;
      t_r     <= t_n;
      tmo_r   <= tmo_n;
    end
  end

  // Slice buffer; contents persist across jobs, only the first S entries are read.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      buf_a_r[wr_idx_s] <= in_a;
      buf_b_r[wr_idx_s] <= in_b;
    end
  end

  // Registered outputs, derived from the state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_ready_r <= 1'b0;
      busy_r     <= 1'b0;
      job_done_r <= 1'b0;
      job_err_r  <= 1'b0;
      pe_reset_r <= 1'b0;
      pe_start_r <= 1'b0;
      pe_fs_r    <= 3'(N);
      pe_a_r     <= '0;
      pe_b_r     <= '0;
    end else begin
      in_ready_r <= (state_n == ST_IDLE) || (state_n == ST_LOAD);
      busy_r     <= (state_n != ST_IDLE);
      job_done_r <= job_done_n;
      job_err_r  <= job_err_n;
      pe_a_r     <= skew_a_s;
      pe_b_r     <= skew_b_s;
      case (state_n)
        ST_CLEAR: begin
          pe_reset_r <= 1'b0;
          pe_start_r <= 1'b0;
          pe_fs_r    <= s_n;
        end
        ST_STREAM, ST_DRAIN: begin
          pe_reset_r <= 1'b1;
          pe_start_r <= 1'b1;
        end
        default: begin
          // Hold array controls so results stay stable between jobs.
          pe_reset_r <= pe_reset_r;
          pe_start_r <= pe_start_r;
        end
      endcase
    end
  end

`ifdef PE_SEQ_PERF_CNT_EN
  logic [15:0] perf_r;

  // Job cycle counter: restarts on a first beat, runs while busy, saturates.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_r <= 16'd0;
    end else if ((state_r == ST_IDLE) && accept_s) begin
      perf_r <= 16'd1;
    end else if ((state_r != ST_IDLE) && (perf_r != 16'hFFFF)) begin
      perf_r <= perf_r + 16'd1;
    end else begin
      perf_r <= perf_r;
    end
  end

  assign perf_cycles = perf_r;
`endif

  assign in_ready       = in_ready_r;
  assign busy           = busy_r;
  assign job_done       = job_done_r;
  assign job_err        = job_err_r;
  assign pe_reset       = pe_reset_r;
  assign pe_start       = pe_start_r;
  assign pe_filter_size = pe_fs_r;
  assign pe_a           = pe_a_r;
  assign pe_b           = pe_b_r;

endmodule

// File: tb/tb_pe_array_seq.sv
// Directed testbench for pe_array_seq.
module tb_pe_array_seq;

  localparam int W = 80;

  logic         clk, reset, in_valid, in_ready, pe_reset, pe_start, pe_done;
  logic         busy, job_done, job_err;
  logic [2:0]   in_filter_size, pe_filter_size;
  logic [W-1:0] in_a, in_b, pe_a, pe_b;
`ifdef PE_SEQ_PERF_CNT_EN
  logic [15:0]  perf_cycles;
`endif

  int tests = 0;
  int fails = 0;

  logic [W-1:0] sa [0:4];
  logic [W-1:0] sb [0:4];
  logic [W-1:0] cap_a [0:8];
  logic [W-1:0] cap_b [0:8];
  logic [W-1:0] clr_a, clr_b;
  logic         clr_rst, clr_start, stream_ok, jd_seen;
  logic [2:0]   clr_fs;

  pe_array_seq #(.DATA_WIDTH(16), .N(5), .TIMEOUT(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_filter_size(in_filter_size), .in_a(in_a), .in_b(in_b),
    .pe_reset(pe_reset), .pe_start(pe_start), .pe_filter_size(pe_filter_size),
    .pe_a(pe_a), .pe_b(pe_b), .pe_done(pe_done), .busy(busy),
    .job_done(job_done),
`ifdef PE_SEQ_PERF_CNT_EN
    .job_err(job_err), .perf_cycles(perf_cycles)
`else
    .job_err(job_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected array input for stream step t of an S-sized job.
  function automatic logic [W-1:0] exp_vec(input int t, input int s, input bit use_b);
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < 5; i++) begin
      if (i < s && t - i >= 0 && t - i < s) begin
        v[i*16 +: 16] = use_b ? sb[t-i][i*16 +: 16] : sa[t-i][i*16 +: 16];
      end
    end
    return v;
  endfunction

  task automatic set_distinct();
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 5; i++) begin
        sa[k][i*16 +: 16] = 16'h1000 + 16'(k * 16 + i);
        sb[k][i*16 +: 16] = 16'h2000 + 16'(k * 16 + i);
      end
    end
  endtask

  task automatic send_beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] fs);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_filter_size = fs;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL beat_accept: in_ready=%b required 1", in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Records the CLEAR cycle and ncyc STREAM cycles that follow a last beat.
  task automatic capture(input int ncyc);
    @(negedge clk);
    clr_rst = pe_reset; clr_start = pe_start; clr_fs = pe_filter_size;
    clr_a = pe_a; clr_b = pe_b;
    stream_ok = 1'b1; jd_seen = job_done;
    for (int t = 0; t < ncyc; t++) begin
      @(negedge clk);
      cap_a[t] = pe_a; cap_b[t] = pe_b;
      stream_ok = stream_ok & pe_start & pe_reset & busy & ~in_ready;
      jd_seen = jd_seen | job_done;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({in_ready, pe_reset, pe_start, pe_filter_size, busy, job_done, job_err} !== 9'b000_101_000
        || pe_a !== '0 || pe_b !== '0) begin
      fails++;
      $display("FAIL reset_values: got rdy=%b rst=%b st=%b fs=%0d busy=%b jd=%b je=%b a=%h b=%h required 0 0 0 5 0 0 0 0 0",
               in_ready, pe_reset, pe_start, pe_filter_size, busy, job_done, job_err, pe_a, pe_b);
    end
    reset = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_ready_early: in_ready=%b required 0", in_ready);
    end
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_ready_rise: in_ready=%b busy=%b required 1 0", in_ready, busy);
    end
  endtask

  task automatic test_s5();
    logic [15:0] v [0:4];
    v[0] = 16'h3C00; v[1] = 16'h4000; v[2] = 16'h4200; v[3] = 16'h4400; v[4] = 16'h4500;
    for (int k = 0; k < 5; k++) begin
      sa[k] = {5{v[k]}};
      sb[k] = {5{16'hC000}};
    end
    for (int k = 0; k < 5; k++) send_beat(sa[k], sb[k], 3'd5);
    capture(9);
    tests++;
    if (clr_rst !== 1'b0 || clr_start !== 1'b0 || clr_a !== '0 || clr_b !== '0 || clr_fs !== 3'd5) begin
      fails++;
      $display("FAIL s5_clear: rst=%b st=%b fs=%0d a=%h required 0 0 5 0", clr_rst, clr_start, clr_fs, clr_a);
    end
    tests++;
    if (cap_a[0] !== {64'h0, 16'h3C00}) begin
      fails++; $display("FAIL s5_t0: pe_a=%h required %h", cap_a[0], {64'h0, 16'h3C00});
    end
    tests++;
    if (cap_a[4] !== {16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500} || cap_b[4] !== {5{16'hC000}}) begin
      fails++; $display("FAIL s5_t4: pe_a=%h pe_b=%h", cap_a[4], cap_b[4]);
    end
    tests++;
    if (cap_a[8] !== {16'h4500, 64'h0}) begin
      fails++; $display("FAIL s5_t8: pe_a=%h required %h", cap_a[8], {16'h4500, 64'h0});
    end
    for (int t = 0; t < 9; t++) begin
      tests++;
      if (cap_a[t] !== exp_vec(t, 5, 1'b0) || cap_b[t] !== exp_vec(t, 5, 1'b1)) begin
        fails++; $display("FAIL s5_stream t=%0d: a=%h required %h", t, cap_a[t], exp_vec(t, 5, 1'b0));
      end
    end
    tests++;
    if (stream_ok !== 1'b1 || jd_seen !== 1'b0) begin
      fails++; $display("FAIL s5_stream_ctl: ok=%b jd=%b required 1 0", stream_ok, jd_seen);
    end
    @(negedge clk);
    tests++;
    if (pe_a !== '0 || pe_b !== '0 || pe_start !== 1'b1 || busy !== 1'b1 || job_done !== 1'b0) begin
      fails++; $display("FAIL s5_drain: a=%h st=%b busy=%b jd=%b required 0 1 1 0", pe_a, pe_start, busy, job_done);
    end
    @(negedge clk);
    @(negedge clk);
    pe_done = 1'b1;
    @(negedge clk);
    pe_done = 1'b0;
    tests++;
    if (job_done !== 1'b1 || job_err !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL s5_done: jd=%b je=%b busy=%b rdy=%b required 1 0 0 1", job_done, job_err, busy, in_ready);
    end
    @(negedge clk);
    tests++;
    if (job_done !== 1'b0 || pe_start !== 1'b1 || pe_reset !== 1'b1 || pe_filter_size !== 3'd5) begin
      fails++; $display("FAIL s5_hold: jd=%b st=%b rst=%b fs=%0d required 0 1 1 5", job_done, pe_start, pe_reset, pe_filter_size);
    end
  endtask

  task automatic test_s1();
    pe_done = 1'b1;
    send_beat({5{16'h3C00}}, {5{16'hC000}}, 3'd1);
    capture(1);
    tests++;
    if (clr_fs !== 3'd1 || clr_rst !== 1'b0 || clr_start !== 1'b0) begin
      fails++; $display("FAIL s1_clear: fs=%0d rst=%b st=%b required 1 0 0", clr_fs, clr_rst, clr_start);
    end
    tests++;
    if (cap_a[0] !== {64'h0, 16'h3C00} || cap_b[0] !== {64'h0, 16'hC000} || stream_ok !== 1'b1) begin
      fails++; $display("FAIL s1_stream: a=%h b=%h ok=%b", cap_a[0], cap_b[0], stream_ok);
    end
    @(negedge clk);
    tests++;
    if (job_done !== 1'b0 || jd_seen !== 1'b0) begin
      fails++; $display("FAIL s1_done_ignored: jd=%b seen=%b required 0 0", job_done, jd_seen);
    end
    @(negedge clk);
    pe_done = 1'b0;
    tests++;
    if (job_done !== 1'b1 || job_err !== 1'b0) begin
      fails++; $display("FAIL s1_done: jd=%b je=%b required 1 0", job_done, job_err);
    end
  endtask

  task automatic test_clamp();
    set_distinct();
    send_beat(sa[0], sb[0], 3'd7);
    for (int k = 1; k < 4; k++) send_beat(sa[k], sb[k], 3'd1);
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      fails++; $display("FAIL clamp_still_loading: rdy=%b busy=%b required 1 1", in_ready, busy);
    end
    send_beat(sa[4], sb[4], 3'd1);
    capture(9);
    tests++;
    if (clr_fs !== 3'd5) begin
      fails++; $display("FAIL clamp_fs: pe_filter_size=%0d required 5", clr_fs);
    end
    for (int t = 0; t < 9; t++) begin
      tests++;
      if (cap_a[t] !== exp_vec(t, 5, 1'b0) || cap_b[t] !== exp_vec(t, 5, 1'b1)) begin
        fails++; $display("FAIL clamp_stream t=%0d: a=%h required %h", t, cap_a[t], exp_vec(t, 5, 1'b0));
      end
    end
    @(negedge clk);
    pe_done = 1'b1;
    @(negedge clk);
    pe_done = 1'b0;
    tests++;
    if (job_done !== 1'b1 || job_err !== 1'b0) begin
      fails++; $display("FAIL clamp_done: jd=%b je=%b required 1 0", job_done, job_err);
    end
  endtask

  task automatic test_gaps();
    for (int k = 0; k < 5; k++) begin
      send_beat(sa[k], sb[k], 3'd5);
      if (k < 4) begin
        @(negedge clk);
        if (k == 0) begin
          tests++;
          if (in_ready !== 1'b1 || busy !== 1'b1) begin
            fails++; $display("FAIL gaps_stall: rdy=%b busy=%b required 1 1", in_ready, busy);
          end
        end
        @(negedge clk);
      end
    end
    capture(9);
    for (int t = 0; t < 9; t++) begin
      tests++;
      if (cap_a[t] !== exp_vec(t, 5, 1'b0) || cap_b[t] !== exp_vec(t, 5, 1'b1)) begin
        fails++; $display("FAIL gaps_stream t=%0d: a=%h required %h", t, cap_a[t], exp_vec(t, 5, 1'b0));
      end
    end
    @(negedge clk);
    pe_done = 1'b1;
    @(negedge clk);
    pe_done = 1'b0;
    tests++;
    if (job_done !== 1'b1 || job_err !== 1'b0) begin
      fails++; $display("FAIL gaps_done: jd=%b je=%b required 1 0", job_done, job_err);
    end
  endtask

  task automatic test_timeout();
    int d;
    send_beat(sa[0], sb[0], 3'd2);
    send_beat(sa[1], sb[1], 3'd2);
    capture(3);
    d = 0;
    while (d < 40) begin
      @(negedge clk);
      d++;
      if (job_done === 1'b1) break;
    end
    tests++;
    if (d !== 34 || job_done !== 1'b1 || job_err !== 1'b1) begin
      fails++; $display("FAIL timeout: done at drain cycle %0d jd=%b je=%b required 34 1 1", d, job_done, job_err);
    end
    @(negedge clk);
    tests++;
    if (job_done !== 1'b0 || job_err !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL timeout_pulse: jd=%b je=%b busy=%b required 0 0 0", job_done, job_err, busy);
    end
  endtask

  task automatic test_reset_midjob();
    for (int k = 0; k < 3; k++) send_beat(sa[k], sb[k], 3'd3);
    capture(3);
    @(negedge clk);
    reset = 1'b0;
    #1;
    tests++;
    if ({in_ready, pe_reset, pe_start, pe_filter_size, busy, job_done, job_err} !== 9'b000_101_000
        || pe_a !== '0 || pe_b !== '0) begin
      fails++;
      $display("FAIL midjob_reset: rdy=%b rst=%b st=%b fs=%0d busy=%b jd=%b a=%h required 0 0 0 5 0 0 0",
               in_ready, pe_reset, pe_start, pe_filter_size, busy, job_done, pe_a);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1 || job_done !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL midjob_recover: rdy=%b jd=%b busy=%b required 1 0 0", in_ready, job_done, busy);
    end
    send_beat(sa[0], sb[0], 3'd2);
    send_beat(sa[1], sb[1], 3'd2);
    capture(3);
    tests++;
    if (clr_fs !== 3'd2) begin
      fails++; $display("FAIL s2_fs: pe_filter_size=%0d required 2", clr_fs);
    end
    for (int t = 0; t < 3; t++) begin
      tests++;
      if (cap_a[t] !== exp_vec(t, 2, 1'b0) || cap_b[t] !== exp_vec(t, 2, 1'b1)) begin
        fails++; $display("FAIL s2_stream t=%0d: a=%h required %h", t, cap_a[t], exp_vec(t, 2, 1'b0));
      end
    end
    @(negedge clk);
    pe_done = 1'b1;
    @(negedge clk);
    pe_done = 1'b0;
    tests++;
    if (job_done !== 1'b1 || job_err !== 1'b0) begin
      fails++; $display("FAIL s2_done: jd=%b je=%b required 1 0", job_done, job_err);
    end
`ifdef PE_SEQ_PERF_CNT_EN
    tests++;
    if (perf_cycles !== 16'd7) begin
      fails++; $display("FAIL s2_perf: perf_cycles=%0d required 7", perf_cycles);
    end
`endif
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_filter_size = 3'd0;
    in_a = '0; in_b = '0; pe_done = 1'b0;
    test_reset();
    test_s5();
    test_s1();
    test_clamp();
    test_gaps();
    test_timeout();
    test_reset_midjob();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
